disk_loader: RTL and testbench
==============================

Name: disk_loader

Overview:
- DMA-style disk controller sitting directly upstream of the main RAM's transfer port.
- On a start command it copies a block of LEN words from secondary storage (synchronous-read disk array) into RAM.
- It drives the RAM's addr_t/data_t/tr/ldd inputs and holds ldd high for the whole copy, so the RAM ignores processor writes meanwhile.
- Used at boot and on explicit load commands.

Parameters:
- DATA_WIDTH, 16, word width of disk and RAM.
- ADDR_WIDTH, 16, width of disk address, RAM address and length.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  command strobe; sampled only in IDLE.
- src  input  ADDR_WIDTH  disk start address, latched on accepted start.
- dst  input  ADDR_WIDTH  RAM start address, latched on accepted start.
- len  input  ADDR_WIDTH  word count, latched on accepted start; 0 is legal.
- disk_addr  output  ADDR_WIDTH  disk read address.
- disk_rd  output  1  disk read strobe.
- disk_data  input  DATA_WIDTH  disk read data, valid the cycle after disk_rd.
- addr_t  output  ADDR_WIDTH  RAM transfer address.
- data_t  output  DATA_WIDTH  RAM transfer data.
- tr  output  1  RAM transfer write enable.
- ldd  output  1  RAM port select; 1 = disk port owns writes.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset:
  - Sync reset gives state IDLE.
  - Pointer, count and data registers are cleared to 0.
  - Every output is 0 from the cycle after rst is sampled high.
  - rst dominates start.
- Outputs decode from registered state/pointers only (Moore). No combinational path from start or disk_data to any output.
- States: IDLE, RD, WT, WR, DONE.
- IDLE:
  - busy=0, ldd=0, tr=0, disk_rd=0.
  - On start=1: latch src into sptr, dst into dptr, len into cnt.
  - If len==0 go to DONE, otherwise go to RD.
- RD: disk_addr=sptr, disk_rd=1, busy=1, ldd=1. Next state WT.
- WT: busy=1, ldd=1; capture disk_data into dreg. Next state WR.
- WR:
  - tr=1, ldd=1, busy=1, addr_t=dptr, data_t=dreg.
  - At exit: sptr+=1, dptr+=1, cnt-=1.
  - If cnt==1 (this is the last word) go to DONE, otherwise go to RD.
- DONE: done=1, busy=0, ldd=0, tr=0. Next state IDLE unconditionally.
- start is ignored in RD, WT, WR and DONE. It is not queued.
- Pointer values:
  - addr_t always shows dptr and data_t always shows dreg, including outside WR.
  - disk_addr always shows sptr.
- Arithmetic:
  - sptr and dptr increment modulo 2^ADDR_WIDTH: 0xFFFF wraps to 0x0000 with no error.
  - cnt is ADDR_WIDTH bits, so the maximum transfer is 2^ADDR_WIDTH-1 words.
- Timing (cycle 0 = start sampled in IDLE):
  - Word i has disk_rd in cycle 1+3i and tr in cycle 3+3i.
  - done occurs in cycle 3N+1, and IDLE resumes in cycle 3N+2.
  - A new start is accepted from cycle 3N+2.
  - For len=0, done occurs in cycle 1 with no disk_rd and no tr.
- Mid-transfer reset:
  - Abort to IDLE and drop ldd/tr the next cycle.
  - Words already written stay in RAM. No done pulse.
- tr is never 1 while ldd is 0.

Test Plan:
- Basic copy: disk[0x10..0x13]=A1,B2,C3,D4; start src=0x10, dst=0x200, len=4 -> tr in cycles 3,6,9,12 with addr_t 0x200..0x203 and matching data; done in cycle 13; RAM holds A1..D4; ldd high in cycles 1-12 only.
- Zero length: start with len=0 -> done in cycle 1; disk_rd, tr and ldd stay 0 throughout.
- Wrap-around: src=0xFFFE, dst=0xFFFF, len=3 -> disk_addr sequence FFFE, FFFF, 0000; addr_t sequence FFFF, 0000, 0001; done in cycle 10.
- Ignored start: pulse start in cycles 2, 5 and 7 of a len=2 copy, and again in the DONE cycle 7 -> no relatch, exactly 2 tr pulses, single done; a start in cycle 8 is accepted.
- Reset mid-operation: len=5, assert rst in cycle 7 -> from cycle 8 all outputs are 0 and state is IDLE; exactly 2 words written; no done; a later start of len=1 completes normally.
- Port ownership: assert RAM we during the copy -> the RAM contents show only disk-port writes during cycles with ldd=1.

Source files
------------

// File: rtl/disk_loader_if.sv
// Command, disk-read and RAM-transfer signals of the disk loader, bundled so the
// controller and its environment connect through one port.
interface disk_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    // start is a one-cycle command, taken only while the loader is idle (busy=0, done=0);
    // it is neither queued nor acknowledged. busy covers the copy, done pulses once after it.
    logic                  start;
    logic [ADDR_WIDTH-1:0] src;
    logic [ADDR_WIDTH-1:0] dst;
    logic [ADDR_WIDTH-1:0] len;
    logic                  busy;
    logic                  done;

    logic [ADDR_WIDTH-1:0] disk_addr;
    logic                  disk_rd;
    logic [DATA_WIDTH-1:0] disk_data;

    logic [ADDR_WIDTH-1:0] addr_t;
    logic [DATA_WIDTH-1:0] data_t;
    logic                  tr;
    logic                  ldd;

    modport master (
        input  start, src, dst, len, disk_data,
        output busy, done, disk_addr, disk_rd, addr_t, data_t, tr, ldd
    );

    modport slave (
        output start, src, dst, len, disk_data,
        input  busy, done, disk_addr, disk_rd, addr_t, data_t, tr, ldd
    );
endinterface

// File: rtl/disk_loader.sv
// DMA copy of a block of words from a synchronous-read disk into RAM through the
// RAM transfer port; ldd keeps the processor off the RAM for the whole copy.
module disk_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    disk_loader_if.master bus,
    output logic [2:0]    state_dbg
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WT   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] sptr, dptr, cnt;
    logic [DATA_WIDTH-1:0] dreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sptr  <= '0;
            dptr  <= '0;
            cnt   <= '0;
            dreg  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sptr <= bus.src;
                        dptr <= bus.dst;
                        cnt  <= bus.len;
                    end
                end
                WT: dreg <= bus.disk_data;
                WR: begin
                    sptr <= sptr + ADDR_WIDTH'(1);
                    dptr <= dptr + ADDR_WIDTH'(1);
                    cnt  <= cnt - ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs depend on the registered state only, so start and disk_data never reach a pin.
    always_comb begin
        state_nx    = state;
        bus.busy    = 1'b0;
        bus.ldd     = 1'b0;
        bus.tr      = 1'b0;
        bus.disk_rd = 1'b0;
        bus.done    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nx = (bus.len == '0) ? DONE : RD;
            end
            RD: begin
                bus.busy    = 1'b1;
                bus.ldd     = 1'b1;
                bus.disk_rd = 1'b1;
                state_nx    = WT;
            end
            WT: begin
                bus.busy = 1'b1;
                bus.ldd  = 1'b1;
                state_nx = WR;
            end
            WR: begin
                bus.busy = 1'b1;
                bus.ldd  = 1'b1;
                bus.tr   = 1'b1;
                state_nx = (cnt == ADDR_WIDTH'(1)) ? DONE : RD;
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.disk_addr = sptr;
    assign bus.addr_t    = dptr;
    assign bus.data_t    = dreg;
    assign state_dbg     = state;
endmodule

// File: tb/tb_disk_loader.sv
// Directed bench for disk_loader: behavioural disk and RAM models around the DUT,
// one task per scenario, cycle numbers counted from the cycle start is sampled.
module tb_disk_loader;
    localparam int DW = 16;
    localparam int AW = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] state_dbg;

    disk_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    disk_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] disk_mem [0:65535];
    logic [DW-1:0] ram      [0:65535];
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;

    int total = 0;
    int bad   = 0;

    // Disk answers one cycle after disk_rd; RAM takes the disk port while ldd=1.
    always @(posedge clk) begin
        if (bus.disk_rd) bus.disk_data <= disk_mem[bus.disk_addr];
        if (bus.ldd) begin
            if (bus.tr) ram[bus.addr_t] <= bus.data_t;
        end else if (cpu_we) begin
            ram[cpu_addr] <= cpu_data;
        end
    end

    // Expected {busy, ldd, tr, disk_rd, done} in cycle c of an n-word copy started in cycle 0.
    function automatic logic [4:0] exp_ctl(int c, int n);
        logic act, t, r, d;
        act = (n > 0) && (c >= 1) && (c <= 3 * n);
        t   = act && (c % 3 == 0);
        r   = act && (c % 3 == 1);
        d   = (c == 3 * n + 1);
        return {act, act, t, r, d};
    endfunction

    function automatic logic [4:0] ctl();
        return {bus.busy, bus.ldd, bus.tr, bus.disk_rd, bus.done};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_we = 1'b1; cpu_addr = a; cpu_data = d;
        next_cycle();
        cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b1; bus.src = 16'h1234; bus.dst = 16'h5678; bus.len = 16'd3;
        cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (ctl() !== 5'b0 || state_dbg !== 3'd0) begin
            bad++; $display("FAIL reset_ctl got=%b/%0d exp=00000/0", ctl(), state_dbg);
        end
        total++;
        if (bus.disk_addr !== 16'h0 || bus.addr_t !== 16'h0 || bus.data_t !== 16'h0) begin
            bad++; $display("FAIL reset_regs got=%h/%h/%h exp=0000/0000/0000", bus.disk_addr, bus.addr_t, bus.data_t);
        end
        next_cycle();
        rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        total++;
        if (ctl() !== 5'b0 || state_dbg !== 3'd0) begin
            bad++; $display("FAIL reset_release got=%b/%0d exp=00000/0", ctl(), state_dbg);
        end
        next_cycle();
    endtask

    task automatic test_basic_copy();
        logic [DW-1:0] w [0:3];
        w[0] = 16'h00A1; w[1] = 16'h00B2; w[2] = 16'h00C3; w[3] = 16'h00D4;
        for (int i = 0; i < 4; i++) disk_mem[16'h10 + i] = w[i];
        for (int c = 0; c <= 15; c++) begin
            bus.start = (c == 0); bus.src = 16'h0010; bus.dst = 16'h0200; bus.len = 16'd4;
            cpu_we   = (c >= 1 && c <= 12) || (c == 14);
            cpu_addr = (c == 14) ? 16'h0210 : 16'h0201;
            cpu_data = (c == 14) ? 16'h5A5A : 16'hDEAD;
            @(negedge clk);
            total++;
            if (ctl() !== exp_ctl(c, 4)) begin
                bad++; $display("FAIL basic_ctl c=%0d got=%b exp=%b", c, ctl(), exp_ctl(c, 4));
            end
            if (c >= 3 && c <= 12 && c % 3 == 0) begin
                total++;
                if (bus.addr_t !== 16'h0200 + 16'(c / 3 - 1) || bus.data_t !== w[c / 3 - 1]) begin
                    bad++; $display("FAIL basic_tr c=%0d got=%h:%h exp=%h:%h", c, bus.addr_t, bus.data_t,
                                    16'h0200 + 16'(c / 3 - 1), w[c / 3 - 1]);
                end
            end
            if (c >= 1 && c <= 10 && c % 3 == 1) begin
                total++;
                if (bus.disk_addr !== 16'h0010 + 16'((c - 1) / 3)) begin
                    bad++; $display("FAIL basic_daddr c=%0d got=%h exp=%h", c, bus.disk_addr, 16'h0010 + 16'((c - 1) / 3));
                end
            end
            next_cycle();
        end
        cpu_we = 1'b0; bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ram[16'h0200 + i] !== w[i]) begin
                bad++; $display("FAIL basic_ram i=%0d got=%h exp=%h", i, ram[16'h0200 + i], w[i]);
            end
        end
        total++;
        if (ram[16'h0210] !== 16'h5A5A) begin
            bad++; $display("FAIL cpu_after_copy got=%h exp=5a5a", ram[16'h0210]);
        end
    endtask

    task automatic test_zero_len();
        for (int c = 0; c <= 3; c++) begin
            bus.start = (c == 0); bus.src = 16'h0005; bus.dst = 16'h0006; bus.len = 16'd0;
            @(negedge clk);
            total++;
            if (ctl() !== exp_ctl(c, 0)) begin
                bad++; $display("FAIL zero_ctl c=%0d got=%b exp=%b", c, ctl(), exp_ctl(c, 0));
            end
            if (c == 1) begin
                total++;
                if (bus.addr_t !== 16'h0006 || bus.disk_addr !== 16'h0005) begin
                    bad++; $display("FAIL zero_latch got=%h/%h exp=0006/0005", bus.addr_t, bus.disk_addr);
                end
            end
            next_cycle();
        end
        bus.start = 1'b0;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_da [0:2];
        logic [AW-1:0] exp_at [0:2];
        logic [DW-1:0] exp_dt [0:2];
        exp_da[0] = 16'hFFFE; exp_da[1] = 16'hFFFF; exp_da[2] = 16'h0000;
        exp_at[0] = 16'hFFFF; exp_at[1] = 16'h0000; exp_at[2] = 16'h0001;
        exp_dt[0] = 16'h1111; exp_dt[1] = 16'h2222; exp_dt[2] = 16'h3333;
        for (int i = 0; i < 3; i++) disk_mem[exp_da[i]] = exp_dt[i];
        for (int c = 0; c <= 11; c++) begin
            bus.start = (c == 0); bus.src = 16'hFFFE; bus.dst = 16'hFFFF; bus.len = 16'd3;
            @(negedge clk);
            total++;
            if (ctl() !== exp_ctl(c, 3)) begin
                bad++; $display("FAIL wrap_ctl c=%0d got=%b exp=%b", c, ctl(), exp_ctl(c, 3));
            end
            if (c >= 1 && c <= 7 && c % 3 == 1) begin
                total++;
                if (bus.disk_addr !== exp_da[(c - 1) / 3]) begin
                    bad++; $display("FAIL wrap_daddr c=%0d got=%h exp=%h", c, bus.disk_addr, exp_da[(c - 1) / 3]);
                end
            end
            if (c >= 3 && c <= 9 && c % 3 == 0) begin
                total++;
                if (bus.addr_t !== exp_at[c / 3 - 1] || bus.data_t !== exp_dt[c / 3 - 1]) begin
                    bad++; $display("FAIL wrap_tr c=%0d got=%h:%h exp=%h:%h", c, bus.addr_t, bus.data_t,
                                    exp_at[c / 3 - 1], exp_dt[c / 3 - 1]);
                end
            end
            next_cycle();
        end
        bus.start = 1'b0;
        total++;
        if (ram[16'hFFFF] !== 16'h1111 || ram[16'h0000] !== 16'h2222 || ram[16'h0001] !== 16'h3333) begin
            bad++; $display("FAIL wrap_ram got=%h,%h,%h exp=1111,2222,3333", ram[16'hFFFF], ram[16'h0000], ram[16'h0001]);
        end
    endtask

    task automatic test_ignored_start();
        int n_tr = 0;
        int n_done = 0;
        logic [4:0] e;
        disk_mem[16'h0020] = 16'h0A0A; disk_mem[16'h0021] = 16'h0B0B; disk_mem[16'h0030] = 16'h0C0C;
        for (int c = 0; c <= 13; c++) begin
            bus.start = (c == 0) || (c == 2) || (c == 5) || (c == 7) || (c == 8);
            if (c == 0) begin
                bus.src = 16'h0020; bus.dst = 16'h0220; bus.len = 16'd2;
            end else if (c == 8) begin
                bus.src = 16'h0030; bus.dst = 16'h0300; bus.len = 16'd1;
            end else begin
                bus.src = 16'h0050; bus.dst = 16'h0500; bus.len = 16'd0;
            end
            @(negedge clk);
            e = (c < 8) ? exp_ctl(c, 2) : exp_ctl(c - 8, 1);
            total++;
            if (ctl() !== e) begin
                bad++; $display("FAIL ign_ctl c=%0d got=%b exp=%b", c, ctl(), e);
            end
            if (c < 8 && bus.tr === 1'b1) n_tr++;
            if (c < 8 && bus.done === 1'b1) n_done++;
            if (c == 6) begin
                total++;
                if (bus.addr_t !== 16'h0221 || bus.data_t !== 16'h0B0B) begin
                    bad++; $display("FAIL ign_norelatch got=%h:%h exp=0221:0b0b", bus.addr_t, bus.data_t);
                end
            end
            if (c == 11) begin
                total++;
                if (bus.addr_t !== 16'h0300 || bus.data_t !== 16'h0C0C) begin
                    bad++; $display("FAIL ign_accept got=%h:%h exp=0300:0c0c", bus.addr_t, bus.data_t);
                end
            end
            next_cycle();
        end
        bus.start = 1'b0;
        total++;
        if (n_tr != 2 || n_done != 1) begin
            bad++; $display("FAIL ign_pulses got=tr%0d/done%0d exp=tr2/done1", n_tr, n_done);
        end
        total++;
        if (ram[16'h0220] !== 16'h0A0A || ram[16'h0221] !== 16'h0B0B || ram[16'h0300] !== 16'h0C0C) begin
            bad++; $display("FAIL ign_ram got=%h,%h,%h exp=0a0a,0b0b,0c0c", ram[16'h0220], ram[16'h0221], ram[16'h0300]);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) disk_mem[16'h0040 + i] = 16'h4000 + 16'(i);
        cpu_write(16'h0402, 16'h7777);
        for (int c = 0; c <= 12; c++) begin
            bus.start = (c == 0); bus.src = 16'h0040; bus.dst = 16'h0400; bus.len = 16'd5;
            rst = (c == 7);
            @(negedge clk);
            total++;
            if (ctl() !== ((c <= 7) ? exp_ctl(c, 5) : 5'b0)) begin
                bad++; $display("FAIL mrst_ctl c=%0d got=%b exp=%b", c, ctl(), (c <= 7) ? exp_ctl(c, 5) : 5'b0);
            end
            if (c >= 8) begin
                total++;
                if (state_dbg !== 3'd0 || bus.disk_addr !== 16'h0 || bus.addr_t !== 16'h0 || bus.data_t !== 16'h0) begin
                    bad++; $display("FAIL mrst_regs c=%0d got=%0d/%h/%h/%h exp=0/0000/0000/0000", c, state_dbg,
                                    bus.disk_addr, bus.addr_t, bus.data_t);
                end
            end
            next_cycle();
        end
        rst = 1'b0;
        total++;
        if (ram[16'h0400] !== 16'h4000 || ram[16'h0401] !== 16'h4001 || ram[16'h0402] !== 16'h7777) begin
            bad++; $display("FAIL mrst_ram got=%h,%h,%h exp=4000,4001,7777", ram[16'h0400], ram[16'h0401], ram[16'h0402]);
        end
        for (int c = 0; c <= 5; c++) begin
            bus.start = (c == 0); bus.src = 16'h0044; bus.dst = 16'h0410; bus.len = 16'd1;
            @(negedge clk);
            total++;
            if (ctl() !== exp_ctl(c, 1)) begin
                bad++; $display("FAIL mrst_after c=%0d got=%b exp=%b", c, ctl(), exp_ctl(c, 1));
            end
            next_cycle();
        end
        bus.start = 1'b0;
        total++;
        if (ram[16'h0410] !== 16'h4004) begin
            bad++; $display("FAIL mrst_after_ram got=%h exp=4004", ram[16'h0410]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_zero_len();
        test_wrap();
        test_ignored_start();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
